// File: rtl/data_bus_mmio.sv
// data_bus_mmio: memory-side slave for the multicycle RV32I core.
// Decodes one address/data/byte-enable port into word RAM (async read),
// an 8N1 UART transmitter fed by a TX FIFO, and a free-running 64-bit
// cycle counter. Read data is combinational because the core samples it
// in the same cycle it drives the address.
module data_bus_mmio #(
    parameter int          RAM_WORDS     = 4096,
    parameter string       MEM_INIT_FILE = "",
    parameter logic [31:0] MMIO_BASE     = 32'h1000_0000,
    parameter int          CLK_DIV       = 16,
    parameter int          FIFO_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_be,
    input  logic        bus_we,
    output logic [31:0] bus_rdata,
    output logic        uart_tx
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          BW        = $clog2(CLK_DIV);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    // ---------------- address decode ----------------
    logic          ram_hit;
    logic          mmio_hit;
    logic [1:0]    reg_sel;
    logic [AW-1:0] ram_idx;

    // addr[1:0] never takes part in selecting a word
    assign ram_hit  = {1'b0, bus_addr} < RAM_BYTES;
    assign mmio_hit = bus_addr[31:4] == MMIO_BASE[31:4];
    assign reg_sel  = bus_addr[3:2];
    assign ram_idx  = bus_addr[AW+1:2];

    // ---------------- RAM ----------------
    logic [31:0] mem [RAM_WORDS];

    // Byte-masked write; contents are deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (bus_we && ram_hit) begin
            for (int i = 0; i < 4; i++)
                if (bus_be[i]) mem[ram_idx][8*i +: 8] <= bus_wdata[8*i +: 8];
        end
    end

    // ---------------- cycle counter ----------------
    logic [63:0] cycle;

    // Free-running, wraps naturally at 2^64.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle <= '0;
        else       cycle <= cycle + 64'd1;
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    logic          empty, full, overflow;
    logic          push_req, push, pop, ovf_clr;

    assign empty    = count == '0;
    assign full     = count == (PW+1)'(FIFO_DEPTH);
    assign push_req = bus_we && mmio_hit && (reg_sel == 2'd0) && bus_be[0];
    // a pop on the same edge frees the slot a full FIFO needs
    assign push     = push_req && (!full || pop);
    assign ovf_clr  = bus_we && mmio_hit && (reg_sel == 2'd1) && bus_be[0] && bus_wdata[3];

    // FIFO storage, no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push) fifo[wptr] <= bus_wdata[7:0];
    end

    // Pointers, occupancy and sticky overflow (a new drop beats a clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
            if (push_req && !push) overflow <= 1'b1;
            else if (ovf_clr)      overflow <= 1'b0;
        end
    end

    // ---------------- UART transmitter ----------------
    tx_state_t     state, state_nx;
    logic [BW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          baud_end;

    assign baud_end = baud == BW'(CLK_DIV - 1);

    // Next state, FIFO pop and line level; uart_tx follows state so reset
    // forces the line high without waiting for a clock.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        uart_tx  = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = S_START;
                end
            end
            S_START: begin
                uart_tx = 1'b0;
                if (baud_end) state_nx = S_DATA;
            end
            S_DATA: begin
                uart_tx = shreg[0];
                if (baud_end && bit_cnt == 3'd7) state_nx = S_STOP;
            end
            S_STOP: begin
                // chain straight into the next start bit when more is queued
                if (baud_end) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = S_START;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, baud timer, bit counter and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state || baud_end) baud <= '0;
            else                               baud <= baud + BW'(1);
            if (pop) begin
                shreg   <= fifo[rptr];
                bit_cnt <= '0;
            end else if (state == S_DATA && baud_end) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // ---------------- read mux ----------------
    // Reads are side-effect free; unmapped space returns zero.
    always_comb begin
        bus_rdata = '0;
        if (ram_hit) begin
            bus_rdata = mem[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                2'd0:    bus_rdata = '0;
                2'd1:    bus_rdata = {28'd0, overflow, state != S_IDLE, full, empty};
                2'd2:    bus_rdata = cycle[31:0];
                default: bus_rdata = cycle[63:32];
            endcase
        end
    end

endmodule
